led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//   Parametrised LED pattern engine for the PL status LEDs. Runtime-programmable
//   prescaler produces a step tick. The pattern register advances once per tick
//   in one of four modes: up count, down count, rotate, bounce.
//   Mode changes use a valid/ready handshake and take effect on a tick boundary.
//   Replaces the fixed free-running counter plus shift/count LED drivers in the static top.
// PARAMETERS
//   LED_W   4    pattern / LED width; legal range 2..16
//   DIV_W   24   prescaler width; tick period = div+1 cycles
// PORTS
//   pl_clk      in   1       clock
//   pl_resetn   in   1       reset, asynchronous, active-low
//   en          in   1       run enable; 0 freezes prescaler and pattern
//   div         in   DIV_W   prescaler terminal value, sampled every cycle
//   mode        in   2       requested mode: 0 UP, 1 DOWN, 2 ROTATE, 3 BOUNCE
//   mode_valid  in   1       mode request valid
//   mode_ready  out  1       engine can accept a mode request
//   led_out     out  LED_W   current pattern (registered)
//   tick        out  1       1-cycle step pulse (registered)
//   wrap        out  1       1-cycle pulse on pattern wrap (registered)
// BEHAVIOUR
//   Reset (async, immediate):
//   - cnt=0, led_out=0, tick=0, wrap=0, mode_ready=1
//   - cur_mode=UP, pending=0, dir=LEFT
//   Prescaler:
//   - en=1 and cnt>=div: cnt<=0, tick<=1; en=1 otherwise: cnt<=cnt+1, tick<=0
//   - en=0: cnt holds, tick<=0
//   - div=0 gives tick every enabled cycle
//   - div lowered below cnt: tick on the next enabled cycle (>= compare, no 2^DIV_W rollover)
//   Pattern:
//   - Updates on the same edge that registers tick=1 (same cycle as the tick condition)
//   - UP: led+1 mod 2^LED_W; wrap when all-ones -> 0
//   - DOWN: led-1 mod 2^LED_W; wrap when 0 -> all-ones
//   - ROTATE: rotate left one bit; wrap when MSB -> LSB
//   - ROTATE: non-one-hot content is rotated as-is (no correction)
//   - BOUNCE: one-hot walk; dir LEFT shifts left, flips to RIGHT on reaching MSB;
//     RIGHT shifts right, flips to LEFT on reaching LSB
//   - BOUNCE wrap asserts on the step that lands on LSB moving RIGHT
//   - wrap asserts only together with tick
//   Mode handshake:
//   - Accept when mode_valid & mode_ready: latch mode into pend_mode, pending<=1, mode_ready<=0
//   - A request accepted in a tick cycle is applied at the NEXT tick, not the current one
//   - At the first tick with pending=1: cur_mode<=pend_mode, pending<=0, mode_ready<=1,
//     dir<=LEFT, led_out<=seed, wrap<=0, no pattern step that tick
//   - Seeds: UP 0, DOWN all-ones, ROTATE/BOUNCE 1
//   - mode_valid while mode_ready=0 is ignored; requester must hold valid
//   - en=0 keeps any pending request pending
//   - Re-requesting the current mode still reloads the seed
//   Reset mid-operation: pending request discarded; all state to reset values.
// TESTING
//   LED_W=4, DIV_W=8.
//   1. UP: reset, div=3, en=1 -> tick every 4th cycle; led_out 0,1,..,F,0;
//      wrap only on F->0 (16th tick)
//   2. BOUNCE: mode=3 valid mid-count -> mode_ready=0 until next tick;
//      led_out 1,2,4,8,4,2,1; wrap only on 2->1; mode_ready=1 again
//   3. DOWN: mode=1 -> led_out F,E,..,0,F; wrap on 0->F; request in tick cycle applies one tick later
//   4. Prescaler: div=0 -> tick every cycle; div=10, cnt=7, div->2 ->
//      tick next cycle, then every 3 cycles
//   5. Freeze: en=0 for 20 cycles with request pending -> cnt, led_out hold;
//      tick=0; mode_ready=0; applied at first tick after en=1
//   6. Async reset: pl_resetn low mid-BOUNCE between clock edges ->
//      led_out=0, tick=0, wrap=0, mode_ready=1 immediately; UP mode after release

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern engine: programmable prescaler tick drives an up/down/rotate/bounce
// pattern register; mode changes are handshaked and applied on a tick boundary.
module led_pattern_gen #(
  parameter int LED_W = 4,
  parameter int DIV_W = 24
) (
  input  logic             pl_clk,
  input  logic             pl_resetn,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             mode_valid,
  output logic             mode_ready,
  output logic [LED_W-1:0] led_out,
  output logic             tick,
  output logic             wrap
);

  // Handshake: a request transfers on a rising edge where mode_valid and
  // mode_ready are both high; the requester holds mode_valid until then.
  typedef enum logic [1:0] {M_UP = 2'd0, M_DOWN = 2'd1, M_ROT = 2'd2, M_BOUNCE = 2'd3} mode_e;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;

  localparam logic [LED_W-1:0] LED_ONE  = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_ONES = {LED_W{1'b1}};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             ready_q, ready_d;
  logic             pending_q, pending_d;
  mode_e            cur_mode_q, cur_mode_d;
  mode_e            pend_mode_q, pend_mode_d;
  dir_e             dir_q, dir_d;

  logic             step;
  logic [LED_W-1:0] led_shl, led_shr;

  function automatic logic [LED_W-1:0] seed_of(input mode_e m);
    case (m)
      M_UP:    seed_of = '0;
      M_DOWN:  seed_of = LED_ONES;
      default: seed_of = LED_ONE;
    endcase
  endfunction

  // >= compare so a lowered div ticks immediately instead of rolling over.
  assign step    = en && (cnt_q >= div);
  assign led_shl = {led_q[LED_W-2:0], 1'b0};
  assign led_shr = {1'b0, led_q[LED_W-1:1]};

  always_comb begin
    cnt_d       = cnt_q;
    led_d       = led_q;
    tick_d      = 1'b0;
    wrap_d      = 1'b0;
    ready_d     = ready_q;
    pending_d   = pending_q;
    cur_mode_d  = cur_mode_q;
    pend_mode_d = pend_mode_q;
    dir_d       = dir_q;

    if (en) begin
      if (step) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    if (step) begin
      if (pending_q) begin
        // A pending mode replaces the step on this tick with a seed reload.
        cur_mode_d = pend_mode_q;
        pending_d  = 1'b0;
        ready_d    = 1'b1;
        dir_d      = DIR_LEFT;
        led_d      = seed_of(pend_mode_q);
      end else begin
        case (cur_mode_q)
          M_UP: begin
            led_d  = led_q + LED_ONE;
            wrap_d = (led_q == LED_ONES);
          end
          M_DOWN: begin
            led_d  = led_q - LED_ONE;
            wrap_d = (led_q == '0);
          end
          M_ROT: begin
            led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
            wrap_d = led_q[LED_W-1];
          end
          default: begin
            if (dir_q == DIR_LEFT) begin
              led_d = led_shl;
              if (led_shl[LED_W-1]) dir_d = DIR_RIGHT;
            end else begin
              led_d = led_shr;
              if (led_shr[0]) begin
                dir_d  = DIR_LEFT;
                wrap_d = 1'b1;
              end
            end
          end
        endcase
      end
    end

    // ready_q high implies nothing pending, so acceptance never collides with apply.
    if (mode_valid && ready_q) begin
      pend_mode_d = mode_e'(mode);
      pending_d   = 1'b1;
      ready_d     = 1'b0;
    end
  end

  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      cnt_q       <= '0;
      led_q       <= '0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      ready_q     <= 1'b1;
      pending_q   <= 1'b0;
      cur_mode_q  <= M_UP;
      pend_mode_q <= M_UP;
      dir_q       <= DIR_LEFT;
    end else begin
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      ready_q     <= ready_d;
      pending_q   <= pending_d;
      cur_mode_q  <= cur_mode_d;
      pend_mode_q <= pend_mode_d;
      dir_q       <= dir_d;
    end
  end

  assign mode_ready = ready_q;
  assign led_out    = led_q;
  assign tick       = tick_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random traffic, checked
// against an arithmetic reference model through an expected-value queue.
module tb_led_pattern_gen;

  localparam int LED_W = 4;
  localparam int DIV_W = 8;
  localparam int NPOS  = 2 * LED_W - 2;

  logic             pl_clk;
  logic             pl_resetn;
  logic             en;
  logic [DIV_W-1:0] div;
  logic [1:0]       mode;
  logic             mode_valid;
  logic             mode_ready;
  logic [LED_W-1:0] led_out;
  logic             tick;
  logic             wrap;

  int n_chk  = 0;
  int n_pass = 0;

  led_pattern_gen #(.LED_W(LED_W), .DIV_W(DIV_W)) dut (
    .pl_clk     (pl_clk),
    .pl_resetn  (pl_resetn),
    .en         (en),
    .div        (div),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .led_out    (led_out),
    .tick       (tick),
    .wrap       (wrap)
  );

  // ---------------- clock / reset ----------------
  initial pl_clk = 1'b0;
  always #5 pl_clk = ~pl_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Bounce is modelled as a position on a 2*LED_W-2 long circular walk.
  int m_cnt, m_led, m_mode, m_pmode, m_pos;
  bit m_pend, m_ready, m_tick, m_wrap;
  logic [LED_W:0] exp_q[$];

  function automatic int bounce_led(input int p);
    return (p < LED_W) ? (1 << p) : (1 << (NPOS - p));
  endfunction

  function automatic int seed_for(input int md);
    return (md == 0) ? 0 : (md == 1) ? (1 << LED_W) - 1 : 1;
  endfunction

  always @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      m_cnt = 0; m_led = 0; m_mode = 0; m_pmode = 0; m_pos = 0;
      m_pend = 0; m_ready = 1; m_tick = 0; m_wrap = 0;
      exp_q.delete();
    end else begin
      bit t, acc;
      int full;
      full = 1 << LED_W;
      t    = en && (m_cnt >= int'(div));
      acc  = mode_valid && m_ready;
      m_wrap = 0;
      m_tick = t;
      if (en) m_cnt = t ? 0 : m_cnt + 1;
      if (t) begin
        if (m_pend) begin
          m_mode = m_pmode; m_pend = 0; m_ready = 1;
          m_led = seed_for(m_mode); m_pos = 0;
        end else begin
          case (m_mode)
            0: begin m_wrap = (m_led == full - 1); m_led = (m_led + 1) % full; end
            1: begin m_wrap = (m_led == 0); m_led = (m_led + full - 1) % full; end
            2: begin m_wrap = (m_led >= full / 2); m_led = (m_led * 2) % full + m_led / (full / 2); end
            default: begin m_pos = (m_pos + 1) % NPOS; m_wrap = (m_pos == 0); m_led = bounce_led(m_pos); end
          endcase
        end
        exp_q.push_back({m_wrap, LED_W'(m_led)});
      end
      if (acc) begin m_pmode = int'(mode); m_pend = 1; m_ready = 0; end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge pl_clk) begin
    if (pl_resetn) begin
      chk("tick", int'(tick), int'(m_tick));
      chk("mode_ready", int'(mode_ready), int'(m_ready));
      chk("led_hold", int'(led_out), m_led);
      if (!tick) chk("wrap_without_tick", int'(wrap), 0);
      else if (exp_q.size() == 0) chk("unexpected_tick", 1, 0);
      else begin
        logic [LED_W:0] e;
        e = exp_q.pop_front();
        chk("sb_led", int'(led_out), int'(e[LED_W-1:0]));
        chk("sb_wrap", int'(wrap), int'(e[LED_W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge pl_clk);
      cyc++;
    end while (!tick && cyc < 300);
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic req_mode(input int md);
    int g;
    mode = md[1:0];
    mode_valid = 1'b1;
    g = 0;
    while (!mode_ready && g < 500) begin
      @(negedge pl_clk);
      g++;
    end
    if (!mode_ready) chk("handshake_timeout", 0, 1);
    @(posedge pl_clk);
    #1 mode_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    for (int g = 0; g < 300 && m_cnt != v; g++) @(negedge pl_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int bl[6];
    bl = '{2, 4, 8, 4, 2, 1};
    pl_resetn = 1'b0; en = 1'b0; div = '0; mode = '0; mode_valid = 1'b0;
    #12;
    chk("rst_led", int'(led_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_ready", int'(mode_ready), 1);
    @(negedge pl_clk); #2;
    pl_resetn = 1'b1; div = 8'd3; en = 1'b1;

    // UP: 16 ticks, period 4, wrap only on F->0
    for (int i = 1; i <= 16; i++) begin
      wait_tick(cyc);
      if (i > 1) chk("up_period", cyc, 4);
      chk("up_led", int'(led_out), i % 16);
      chk("up_wrap", int'(wrap), int'(i == 16));
    end

    // BOUNCE requested mid-count
    @(negedge pl_clk);
    req_mode(3);
    @(negedge pl_clk);
    chk("bounce_ready_low", int'(mode_ready), 0);
    wait_tick(cyc);
    chk("bounce_seed", int'(led_out), 1);
    chk("bounce_seed_wrap", int'(wrap), 0);
    chk("bounce_ready_back", int'(mode_ready), 1);
    for (int i = 0; i < 6; i++) begin
      wait_tick(cyc);
      chk("bounce_led", int'(led_out), bl[i]);
      chk("bounce_wrap", int'(wrap), int'(i == 5));
    end

    // DOWN requested in a tick cycle: one more bounce step first
    wait_cnt(3);
    req_mode(1);
    wait_tick(cyc);
    chk("down_late_step", int'(led_out), 2);
    chk("down_late_ready", int'(mode_ready), 0);
    wait_tick(cyc);
    chk("down_seed", int'(led_out), 15);
    for (int i = 1; i <= 16; i++) begin
      wait_tick(cyc);
      chk("down_led", int'(led_out), (31 - i) % 16);
      chk("down_wrap", int'(wrap), int'(i == 16));
    end

    // Prescaler: div=0 ticks every cycle; lowering div below cnt ticks next cycle
    div = 8'd0;
    repeat (5) begin
      @(negedge pl_clk);
      chk("div0_tick", int'(tick), 1);
    end
    div = 8'd10;
    wait_cnt(7);
    div = 8'd2;
    @(negedge pl_clk);
    chk("div_lowered_tick", int'(tick), 1);
    repeat (2) begin
      wait_tick(cyc);
      chk("div2_period", cyc, 3);
    end

    // Freeze with a pending ROTATE request
    div = 8'd3;
    wait_tick(cyc);
    @(negedge pl_clk);
    req_mode(2);
    en = 1'b0;
    repeat (20) begin
      @(negedge pl_clk);
      chk("freeze_tick", int'(tick), 0);
      chk("freeze_ready", int'(mode_ready), 0);
    end
    en = 1'b1;
    wait_tick(cyc);
    chk("rot_seed", int'(led_out), 1);
    chk("rot_ready", int'(mode_ready), 1);
    for (int i = 1; i <= 4; i++) begin
      wait_tick(cyc);
      chk("rot_led", int'(led_out), (i == 4) ? 1 : (1 << i));
      chk("rot_wrap", int'(wrap), int'(i == 4));
    end

    // Random traffic, checked by the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: div = DIV_W'($urandom_range(0, 4));
        1: req_mode(int'($urandom_range(0, 3)));
        2: begin
          en = 1'b0;
          repeat ($urandom_range(1, 6)) @(negedge pl_clk);
          en = 1'b1;
        end
        default: repeat ($urandom_range(1, 10)) @(negedge pl_clk);
      endcase
    end

    // Async reset mid-BOUNCE with a request pending
    div = 8'd0;
    req_mode(3);
    repeat (3) wait_tick(cyc);
    mode = 2'd1;
    mode_valid = 1'b1;
    @(posedge pl_clk);
    #3 pl_resetn = 1'b0;
    #1;
    chk("arst_led", int'(led_out), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_wrap", int'(wrap), 0);
    chk("arst_ready", int'(mode_ready), 1);
    mode_valid = 1'b0;
    div = 8'd3;
    repeat (2) @(negedge pl_clk);
    #2 pl_resetn = 1'b1;
    wait_tick(cyc);
    chk("post_rst_led1", int'(led_out), 1);
    chk("post_rst_wrap", int'(wrap), 0);
    wait_tick(cyc);
    chk("post_rst_led2", int'(led_out), 2);

    @(negedge pl_clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
